time_keeper: RTL
================

Name: time_keeper

Overview:
- Time-of-day counter that consumes the set/run strobes from the time-setting state machine (`hours`, `mins`, `secs`).
- Holds hours/minutes/seconds, advances on a 1 Hz tick in run mode, and applies manual hour/minute increments in set mode.
- Its outputs feed the display driver and the alarm comparator.

Parameters:
- MODE_12H, 0, 0 = 24-hour count (0..23); 1 = 12-hour count (1..12) with a pm flag.
- SEC_MAX, 59, terminal value of the seconds and minutes counters. Kept as a parameter only so benches can shorten runs.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- tick_1hz  input  1  single-cycle enable pulse, once per second.
- hours  input  1  hour-increment request from the set state machine (level; acted on at its rising edge).
- mins  input  1  minute-increment request (level; acted on at its rising edge).
- secs  input  1  run enable. 1 = clock runs; 0 = set mode, seconds frozen at 0.
- hour  output  5  current hour (binary).
- min  output  6  current minute (binary).
- sec  output  6  current second (binary).
- pm  output  1  PM flag. Held 0 when MODE_12H = 0.
- day_pulse  output  1  one-cycle pulse when the count wraps past midnight in run mode.
- min_pulse  output  1  one-cycle pulse on every run-mode minute change; used by the alarm comparator.

Behaviour:
- All outputs are registered. Latency from input event to updated outputs is 1 clk.
- Reset (asynchronous, active-high):
  - sec=0, min=0, day_pulse=0, min_pulse=0, pm=0.
  - hour=0 when MODE_12H=0; hour=12 when MODE_12H=1.
  - Edge-detect history for `hours`/`mins` cleared to 0.
  - Reset is allowed mid-count. The next edge after release behaves as from the reset state.
- Edge detection:
  - hours_rise = hours & ~hours_q; mins_rise = mins & ~mins_q.
  - hours_q and mins_q are registered every cycle.
  - A request held high for N cycles produces exactly one increment.
- Set increments (any `secs` value):
  - mins_rise: min = (min==SEC_MAX) ? 0 : min+1. No carry into hour.
  - hours_rise, 24h: 23→0. 12h: 11→12 toggles pm; 12→1 does not. No day_pulse from set increments.
  - hours_rise and mins_rise in the same cycle: both fields increment independently.
- Run mode (`secs`=1):
  - On tick_1hz, sec increments. sec==SEC_MAX wraps to 0 and carries into min.
  - min==SEC_MAX with carry wraps to 0 and carries into hour, using the same hour wrap rules as above.
  - 24h: hour 23→0 via carry asserts day_pulse for 1 cycle. 12h: the carry that takes pm 1→0 (11:59:59 PM → 12:00:00 AM) asserts day_pulse.
  - min_pulse asserts for 1 cycle whenever a seconds carry changes min.
- Set mode (`secs`=0):
  - sec is forced to 0 on every clk.
  - tick_1hz is ignored; no carries, no min_pulse, no day_pulse.
  - On the `secs` 0→1 transition, counting starts from sec=0 at the next tick.
- Collision (set edge and carry targeting the same field in one cycle):
  - The field increments by exactly 1; the carry is absorbed.
  - Any further carry out of that field is suppressed.
  - min_pulse/day_pulse still follow the carry rules.
- Counters never hold out-of-range values. Wrap comparisons use `==`, not `>`.

Decomposition:
- Shared package time_pkg:
  - HOUR_W=5, MIN_W=6, SEC_W=6.
  - HOUR_MAX_24=23, HOUR_MAX_12=12.
  - SEC_MAX default (59).
- Sub-module mod_counter (parameters WIDTH, MIN_VAL, MAX_VAL):
  - Inputs: inc, clr; output: carry (combinational, asserted when inc is high at MAX_VAL).
  - Instantiated for seconds and minutes.
  - Hours stay in the top level because of the 12h/pm special case.

Test Plan:
1. Reset asserted mid-count at 05:17:42, MODE_12H=0 → outputs go to 00:00:00 with pm=0 immediately (asynchronous, before the next clk); hold after release until the next tick.
2. secs=1, start 23:59:58, two tick_1hz pulses → 23:59:59, then 00:00:00. day_pulse and min_pulse each high exactly 1 cycle on the second tick.
3. secs=0, hours held high 5 cycles then low, repeated 3 times from 00:00 → hour=3. min unchanged. sec stays 0 while ticks are ignored.
4. secs=0, mins rising edge at min=59, hour=7 → min=0, hour=7 (no carry). hours and mins rising in the same cycle from 07:00 → 08:01.
5. MODE_12H=1, secs=1, start 11:59:59 pm=0, one tick → 12:00:00 pm=1, day_pulse=0. From 11:59:59 pm=1, one tick → 12:00:00 pm=0, day_pulse=1.
6. secs=1 at 10:59:59, tick_1hz coincident with hours rising edge → 11:00:00 (single hour increment), min_pulse=1, no double count.

Source files
------------

// File: rtl/time_pkg.sv
// Shared widths, limits and the hour-advance rule for the time-of-day counter.
package time_pkg;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;

    localparam int HOUR_MAX_24     = 23;
    localparam int HOUR_MAX_12     = 12;
    localparam int SEC_MAX_DEFAULT = 59;

    // One-step hour advance: 23->0 in 24h mode, 12->1 in 12h mode.
    function automatic logic [HOUR_W-1:0] hour_next(input logic [HOUR_W-1:0] h,
                                                    input logic              mode_12h);
        logic [HOUR_W-1:0] max_h;
        max_h = mode_12h ? HOUR_W'(HOUR_MAX_12) : HOUR_W'(HOUR_MAX_24);
        if (h == max_h) begin
            return mode_12h ? HOUR_W'(1) : '0;
        end
        return h + HOUR_W'(1);
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Wrapping counter MIN_VAL..MAX_VAL with synchronous clear and a combinational carry.
module mod_counter
    import time_pkg::*;
#(
    parameter int WIDTH   = 6,
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 59
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             carry
);

    logic at_max;

    assign at_max = (count == WIDTH'(MAX_VAL));
    assign carry  = inc & at_max;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= WIDTH'(MIN_VAL);
        end else if (clr) begin
            count <= WIDTH'(MIN_VAL);
        end else if (inc) begin
            count <= at_max ? WIDTH'(MIN_VAL) : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/time_keeper.sv
// Time-of-day counter: runs on the 1 Hz tick, takes hour/minute set increments,
// and flags minute changes and midnight wraps for the alarm and display paths.
module time_keeper
    import time_pkg::*;
#(
    parameter bit MODE_12H = 1'b0,
    parameter int SEC_MAX  = SEC_MAX_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick_1hz,
    input  logic              hours,
    input  logic              mins,
    input  logic              secs,
    output logic [HOUR_W-1:0] hour,
    output logic [MIN_W-1:0]  min,
    output logic [SEC_W-1:0]  sec,
    output logic              pm,
    output logic              day_pulse,
    output logic              min_pulse
);

    localparam logic [HOUR_W-1:0] HOUR_RST = MODE_12H ? HOUR_W'(HOUR_MAX_12) : '0;

    logic hours_q;
    logic mins_q;
    logic hours_rise;
    logic mins_rise;
    logic sec_inc;
    logic sec_clr;
    logic sec_carry;
    logic min_inc;
    logic min_wrap;
    logic hour_carry;
    logic hour_inc;
    logic day_next;

    assign hours_rise = hours & ~hours_q;
    assign mins_rise  = mins & ~mins_q;

    // Set mode holds seconds at zero and blocks the tick, so no carries start there.
    assign sec_inc = secs & tick_1hz;
    assign sec_clr = ~secs;

    mod_counter #(
        .WIDTH  (SEC_W),
        .MIN_VAL(0),
        .MAX_VAL(SEC_MAX)
    ) u_sec (
        .clk  (clk),
        .reset(reset),
        .inc  (sec_inc),
        .clr  (sec_clr),
        .count(sec),
        .carry(sec_carry)
    );

    // A minute set edge coinciding with a seconds carry still moves min by one.
    assign min_inc = mins_rise | sec_carry;

    mod_counter #(
        .WIDTH  (MIN_W),
        .MIN_VAL(0),
        .MAX_VAL(SEC_MAX)
    ) u_min (
        .clk  (clk),
        .reset(reset),
        .inc  (min_inc),
        .clr  (1'b0),
        .count(min),
        .carry(min_wrap)
    );

    // Hour carry only from a genuine run-mode rollover; a colliding set edge absorbs it.
    assign hour_carry = sec_carry & min_wrap & ~mins_rise;
    assign hour_inc   = hours_rise | hour_carry;

    always_comb begin
        day_next = 1'b0;
        if (hour_carry) begin
            if (MODE_12H) begin
                day_next = pm && (hour == HOUR_W'(11));
            end else begin
                day_next = (hour == HOUR_W'(HOUR_MAX_24));
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hours_q   <= 1'b0;
            mins_q    <= 1'b0;
            hour      <= HOUR_RST;
            pm        <= 1'b0;
            day_pulse <= 1'b0;
            min_pulse <= 1'b0;
        end else begin
            hours_q   <= hours;
            mins_q    <= mins;
            day_pulse <= day_next;
            min_pulse <= sec_carry;
            if (hour_inc) begin
                hour <= hour_next(hour, MODE_12H);
                if (MODE_12H && (hour == HOUR_W'(11))) begin
                    pm <= ~pm;
                end
            end
        end
    end

endmodule
